axi_tmr_err_monitor: RTL and testbench

Sequential error-tracking stage directly downstream of a bank of WIDTH TMR voter units on a protected AXI bus. It consumes the per-bit replica error indications and:
- keeps saturating per-replica and uncorrectable-error statistics;
- declares a replica failed after PERSIST consecutive errored samples;
- runs a req/ack resync handshake toward the replica-recovery logic;
- raises an interrupt pulse on new fault events.

---
 rtl/axi_tmr_err_monitor_if.sv | 30 +++
 rtl/axi_tmr_err_monitor.sv | 108 ++++++++++
 tb/tb_axi_tmr_err_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_tmr_err_monitor_if.sv
// axi_tmr_err_monitor_if: sample inputs, statistics and resync handshake of the TMR error monitor
//   master: drives sample_valid, err_d0/1/2_vec, clear, resync_ack; observes statistics, flags, resync_req/id, irq
//   slave : the monitor side of the same signals
interface axi_tmr_err_monitor_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
   logic             sample_valid;
   logic [WIDTH-1:0] err_d0_vec;
   logic [WIDTH-1:0] err_d1_vec;
   logic [WIDTH-1:0] err_d2_vec;
   logic             clear;
   logic [CNT_W-1:0] err_cnt0;
   logic [CNT_W-1:0] err_cnt1;
   logic [CNT_W-1:0] err_cnt2;
   logic [CNT_W-1:0] uncorr_cnt;
   logic             uncorr_sticky;
   logic [2:0]       replica_failed;
   logic             resync_req;
   logic [1:0]       resync_id;
   logic             resync_ack;
   logic             irq;
   modport master (
      output sample_valid, err_d0_vec, err_d1_vec, err_d2_vec, clear, resync_ack,
      input  err_cnt0, err_cnt1, err_cnt2, uncorr_cnt, uncorr_sticky, replica_failed,
             resync_req, resync_id, irq
   );
   modport slave (
      input  sample_valid, err_d0_vec, err_d1_vec, err_d2_vec, clear, resync_ack,
      output err_cnt0, err_cnt1, err_cnt2, uncorr_cnt, uncorr_sticky, replica_failed,
             resync_req, resync_id, irq
   );
endinterface

// File: rtl/axi_tmr_err_monitor.sv
// axi_tmr_err_monitor: error statistics, replica failure detection and resync handshake behind a TMR voter bank
//   aclk, areset : clock, synchronous active-high reset
//   bus (slave)  : error sample inputs, clear, saturating counters, sticky flags, resync req/ack, irq pulse
module axi_tmr_err_monitor #(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 16,
   parameter int PERSIST = 4
) (
   input logic                  aclk,
   input logic                  areset,
   axi_tmr_err_monitor_if.slave bus
);
   localparam int RW = $clog2(PERSIST + 1);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLDOFF = 2'd2;
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [RW-1:0] PMAX = RW'(PERSIST);

   logic [WIDTH-1:0] unc;
   logic [2:0]       ce;
   logic             ack_hit;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [RW-1:0]    run_q [3];
   logic [RW-1:0]    run_d [3];
   logic [CNT_W-1:0] ucnt_q, ucnt_d;
   logic             sticky_q, sticky_d;
   logic [2:0]       failed_q, failed_d;
   logic [1:0]       state_q, state_d, id_q, id_d;
   logic             req_q, req_d, irq_q, irq_d;
   logic [RW-1:0]    hold_q, hold_d;

   // uncorrectable bits are masked out before attributing errors to a replica
   assign unc     = bus.err_d0_vec & bus.err_d1_vec & bus.err_d2_vec;
   assign ce      = {|(bus.err_d2_vec & ~unc), |(bus.err_d1_vec & ~unc), |(bus.err_d0_vec & ~unc)};
   assign ack_hit = state_q == REQ && bus.resync_ack;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         cnt_d[k]    = bus.clear ? '0 : (bus.sample_valid && ce[k] && cnt_q[k] != CMAX) ? cnt_q[k] + 1'b1 : cnt_q[k];
         // the replica just resynced is not tracked during holdoff
         run_d[k]    = (!bus.sample_valid || (state_q == HOLDOFF && id_q == 2'(k))) ? run_q[k] :
                       !ce[k] ? '0 : (run_q[k] == PMAX) ? run_q[k] : run_q[k] + 1'b1;
         run_d[k]    = (ack_hit && id_q == 2'(k)) ? '0 : run_d[k];
         failed_d[k] = (ack_hit && id_q == 2'(k)) ? 1'b0 : failed_q[k] | (run_d[k] == PMAX);
      end
      ucnt_d   = bus.clear ? '0 : (bus.sample_valid && |unc && ucnt_q != CMAX) ? ucnt_q + 1'b1 : ucnt_q;
      sticky_d = bus.clear ? 1'b0 : sticky_q | (bus.sample_valid && |unc);
      irq_d    = |(failed_d & ~failed_q) | (sticky_d & ~sticky_q);
      state_d  = state_q;
      id_d     = id_q;
      req_d    = req_q;
      hold_d   = hold_q;
      if (state_q == IDLE && failed_q != 3'b000) begin
         state_d = REQ;
         req_d   = 1'b1;
         id_d    = failed_q[0] ? 2'd0 : failed_q[1] ? 2'd1 : 2'd2;
      end
      if (ack_hit) begin
         state_d = HOLDOFF;
         req_d   = 1'b0;
         hold_d  = PMAX;
      end
      if (state_q == HOLDOFF) begin
         hold_d  = (hold_q == '0) ? hold_q : hold_q - 1'b1;
         state_d = (hold_q == '0) ? IDLE : HOLDOFF;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= '0;
            run_q[k] <= '0;
         end
         ucnt_q   <= '0;
         sticky_q <= 1'b0;
         failed_q <= 3'b000;
         state_q  <= IDLE;
         id_q     <= 2'd0;
         req_q    <= 1'b0;
         irq_q    <= 1'b0;
         hold_q   <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= cnt_d[k];
            run_q[k] <= run_d[k];
         end
         ucnt_q   <= ucnt_d;
         sticky_q <= sticky_d;
         failed_q <= failed_d;
         state_q  <= state_d;
         id_q     <= id_d;
         req_q    <= req_d;
         irq_q    <= irq_d;
         hold_q   <= hold_d;
      end
   end

   assign bus.err_cnt0       = cnt_q[0];
   assign bus.err_cnt1       = cnt_q[1];
   assign bus.err_cnt2       = cnt_q[2];
   assign bus.uncorr_cnt     = ucnt_q;
   assign bus.uncorr_sticky  = sticky_q;
   assign bus.replica_failed = failed_q;
   assign bus.resync_req     = req_q;
   assign bus.resync_id      = id_q;
   assign bus.irq            = irq_q;
endmodule

// File: tb/tb_axi_tmr_err_monitor.sv
// tb_axi_tmr_err_monitor: scoreboard bench for the TMR error monitor
module tb_axi_tmr_err_monitor;
   logic aclk;
   logic areset;
   axi_tmr_err_monitor_if #(.WIDTH(32), .CNT_W(16)) bus ();
   axi_tmr_err_monitor #(.WIDTH(32), .CNT_W(16), .PERSIST(4)) dut (.aclk(aclk), .areset(areset), .bus(bus));

   typedef struct {
      logic [15:0] c0, c1, c2, u;
      logic        s;
      logic        chk;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_c[3];
   logic [15:0] m_u;
   logic        m_s;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_irq = 0;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc(input logic v, input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic clr, input logic ack, input logic chk);
      logic [31:0] u;
      logic [2:0]  ce;
      exp_t        e;
      bus.sample_valid = v;
      bus.err_d0_vec   = d0;
      bus.err_d1_vec   = d1;
      bus.err_d2_vec   = d2;
      bus.clear        = clr;
      bus.resync_ack   = ack;
      u  = d0 & d1 & d2;
      ce = {(d2 & ~u) != 0, (d1 & ~u) != 0, (d0 & ~u) != 0};
      for (int k = 0; k < 3; k++)
         if (clr) m_c[k] = 16'h0;
         else if (v && ce[k] && m_c[k] != 16'hFFFF) m_c[k] = m_c[k] + 16'h1;
      if (clr) begin
         m_u = 16'h0;
         m_s = 1'b0;
      end else if (v && u != 0) begin
         if (m_u != 16'hFFFF) m_u = m_u + 16'h1;
         m_s = 1'b1;
      end
      e = '{m_c[0], m_c[1], m_c[2], m_u, m_s, chk};
      sb.push_back(e);
      @(posedge aclk);
      #1;
      if (bus.irq) n_irq++;
      e = sb.pop_front();
      if (e.chk) begin
         check("err_cnt0", 32'(bus.err_cnt0), 32'(e.c0));
         check("err_cnt1", 32'(bus.err_cnt1), 32'(e.c1));
         check("err_cnt2", 32'(bus.err_cnt2), 32'(e.c2));
         check("uncorr_cnt", 32'(bus.uncorr_cnt), 32'(e.u));
         check("uncorr_sticky", 32'(bus.uncorr_sticky), 32'(e.s));
      end
   endtask

   task automatic idle(input logic ack);
      cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ack, 1'b1);
   endtask

   task automatic do_reset();
      areset           = 1'b1;
      bus.sample_valid = 1'b0;
      bus.err_d0_vec   = 32'h0;
      bus.err_d1_vec   = 32'h0;
      bus.err_d2_vec   = 32'h0;
      bus.clear        = 1'b0;
      bus.resync_ack   = 1'b0;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      for (int k = 0; k < 3; k++) m_c[k] = 16'h0;
      m_u   = 16'h0;
      m_s   = 1'b0;
      n_irq = 0;
      sb.delete();
   endtask

   initial begin
      logic ok;
      int   gap;
      do_reset();
      check("rst_cnt0", 32'(bus.err_cnt0), 0);
      check("rst_cnt1", 32'(bus.err_cnt1), 0);
      check("rst_cnt2", 32'(bus.err_cnt2), 0);
      check("rst_ucnt", 32'(bus.uncorr_cnt), 0);
      check("rst_sticky", 32'(bus.uncorr_sticky), 0);
      check("rst_failed", 32'(bus.replica_failed), 0);
      check("rst_req", 32'(bus.resync_req), 0);
      check("rst_id", 32'(bus.resync_id), 0);
      check("rst_irq", 32'(bus.irq), 0);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         idle(1'b0);
         ok &= !bus.resync_req && bus.replica_failed == 3'b000 && !bus.irq;
      end
      check("idle_quiet", 32'(ok), 1);

      // replica 1 persistence: 3 errors, a clean sample, then 4 errors
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
         ok &= bus.replica_failed == 3'b000;
      end
      check("fail_not_early", 32'(ok), 1);
      cyc(1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
      check("failed_r1", 32'(bus.replica_failed), 32'h2);
      check("err_cnt1_7", 32'(bus.err_cnt1), 7);
      check("irq_r1", 32'(bus.irq), 1);
      idle(1'b0);
      check("irq_one_cycle", 32'(bus.irq), 0);
      check("req_r1", 32'(bus.resync_req), 1);
      check("id_r1", 32'(bus.resync_id), 1);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle(1'b0);
         ok &= bus.resync_req && bus.resync_id == 2'd1;
      end
      check("req_stable", 32'(ok), 1);
      idle(1'b1);
      check("req_drop", 32'(bus.resync_req), 0);
      check("failed_cleared", 32'(bus.replica_failed), 0);
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
         ok &= bus.replica_failed == 3'b000 && !bus.resync_req;
      end
      idle(1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
         ok &= bus.replica_failed == 3'b000 && !bus.resync_req;
      end
      check("holdoff_run_frozen", 32'(ok), 1);
      cyc(1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
      check("refail_r1", 32'(bus.replica_failed), 32'h2);
      check("irq_count_2", 32'(n_irq), 2);

      // uncorrectable bit 0 plus correctable replica 2 on bit 3
      do_reset();
      cyc(1'b1, 32'h1, 32'h1, 32'h9, 1'b0, 1'b0, 1'b1);
      check("unc_sticky", 32'(bus.uncorr_sticky), 1);
      check("unc_ucnt", 32'(bus.uncorr_cnt), 1);
      idle(1'b0);
      idle(1'b0);
      check("unc_irq_single", 32'(n_irq), 1);

      // counter saturation, replica 0 resyncs auto-acked while preloading
      do_reset();
      for (int i = 0; i < 65535; i++) cyc(1'b1, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      check("sat_cnt0", 32'(bus.err_cnt0), 32'hFFFF);
      cyc(1'b1, 32'h3, 32'h2, 32'h2, 1'b0, 1'b1, 1'b1);
      check("sat_sticky", 32'(bus.uncorr_sticky), 1);
      cyc(1'b1, 32'h5, 32'h4, 32'h4, 1'b1, 1'b0, 1'b1);
      check("clear_cnt0", 32'(bus.err_cnt0), 0);
      check("clear_sticky", 32'(bus.uncorr_sticky), 0);

      // replicas 0 and 2 fail together
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10, 32'h0, 32'h100, 1'b0, 1'b0, 1'b1);
      check("dual_failed", 32'(bus.replica_failed), 32'h5);
      check("dual_irq", 32'(n_irq), 1);
      idle(1'b0);
      check("dual_req0", 32'(bus.resync_req), 1);
      check("dual_id0", 32'(bus.resync_id), 0);
      idle(1'b1);
      check("dual_after_ack", 32'(bus.replica_failed), 32'h4);
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         idle(i < 3);
         gap++;
         if (bus.resync_req) break;
      end
      check("dual_req2", 32'(bus.resync_req), 1);
      check("dual_id2", 32'(bus.resync_id), 2);
      check("dual_gap", 32'(gap >= 5), 1);
      check("dual_failed2", 32'(bus.replica_failed), 32'h4);
      do_reset();
      check("rst_req_mid", 32'(bus.resync_req), 0);
      check("rst_failed_mid", 32'(bus.replica_failed), 0);
      idle(1'b0);
      check("rst_stays_idle", 32'(bus.resync_req), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
